// File: rtl/seq_multiplier_if.sv
// Start/done request bus between a requester and the shift-add multiplier.
// Latency: none (wires only).
// Backpressure: none; the requester watches o_Busy/o_Done instead of a ready.
interface seq_multiplier_if #(
  parameter int A_W = 10,
  parameter int B_W = 5
);
  logic               i_Start;
  logic [A_W-1:0]     i_Multiplicand;
  logic [B_W-1:0]     i_Multiplier;
  logic               o_Busy;
  logic               o_Done;
  logic [A_W+B_W-1:0] o_Product;
  logic               o_Ovf;

  // Requester side: drives the request and operands, observes the result.
  modport master (
    output i_Start, i_Multiplicand, i_Multiplier,
    input  o_Busy, o_Done, o_Product, o_Ovf
  );

  // Multiplier side.
  modport slave (
    input  i_Start, i_Multiplicand, i_Multiplier,
    output o_Busy, o_Done, o_Product, o_Ovf
  );
endinterface

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, one multiplier bit per clock, unsigned A*B plus overflow flag.
// Latency: start captured at E0, o_Done high in the cycle after E(B_W); one product per B_W+2 cycles.
// Backpressure: none; i_Start is ignored while busy (no restart, no queuing).
module seq_multiplier #(
  parameter int A_W   = 10,
  parameter int B_W   = 5,
  parameter int LIM_W = 13
) (
  input  logic i_Clk,
  input  logic i_Rst,
  seq_multiplier_if.slave bus
);
  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = (B_W > 1) ? $clog2(B_W) : 1;
  // Largest product still inside the legal result domain.
  localparam logic [P_W-1:0] LIMIT = P_W'((64'd1 << LIM_W) - 64'd1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_State;
  state_t           w_Next;
  logic [A_W-1:0]   r_A;
  logic [B_W-1:0]   r_B;
  logic [P_W-1:0]   r_Acc;
  logic [CNT_W-1:0] r_Cnt;
  logic [P_W-1:0]   r_Product;
  logic             r_Ovf;

  logic [P_W-1:0]   w_Addend;
  logic [P_W-1:0]   w_Sum;
  logic             w_Last;

  // Partial product for the current multiplier bit; accumulator is wide enough never to wrap.
  assign w_Addend = r_B[r_Cnt] ? ({{B_W{1'b0}}, r_A} << r_Cnt) : '0;
  assign w_Sum    = r_Acc + w_Addend;
  assign w_Last   = (r_Cnt == CNT_W'(B_W - 1));

  // State register; reset wins over any start in the same cycle.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) r_State <= S_IDLE;
    else       r_State <= w_Next;
  end

  // Next-state: IDLE waits for a start, RUN takes exactly B_W cycles, DONE lasts one cycle.
  always_comb begin
    w_Next = r_State;
    case (r_State)
      S_IDLE:  if (bus.i_Start) w_Next = S_RUN;
      S_RUN:   if (w_Last) w_Next = S_DONE;
      S_DONE:  w_Next = S_IDLE;
      default: w_Next = S_IDLE;
    endcase
  end

  // Datapath: capture operands on accept, iterate in RUN, publish the result on the last iteration.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_A       <= '0;
      r_B       <= '0;
      r_Acc     <= '0;
      r_Cnt     <= '0;
      r_Product <= '0;
      r_Ovf     <= 1'b0;
    end else begin
      case (r_State)
        S_IDLE: begin
          // Previous product/ovf stay visible until the new result overwrites them.
          if (bus.i_Start) begin
            r_A   <= bus.i_Multiplicand;
            r_B   <= bus.i_Multiplier;
            r_Acc <= '0;
            r_Cnt <= '0;
          end
        end
        S_RUN: begin
          r_Acc <= w_Sum;
          r_Cnt <= r_Cnt + CNT_W'(1);
          if (w_Last) begin
            r_Product <= w_Sum;
            r_Ovf     <= (w_Sum > LIMIT);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: status decoded from state, result straight from its holding registers.
  always_comb begin
    bus.o_Busy    = (r_State != S_IDLE);
    bus.o_Done    = (r_State == S_DONE);
    bus.o_Product = r_Product;
    bus.o_Ovf     = r_Ovf;
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: reference is plain a*b and a threshold compare.
// Latency: checks done timing 5 cycles after capture and 7-cycle throughput.
// Backpressure: checks starts issued while busy are ignored.
module tb_seq_multiplier;
  localparam int A_W   = 10;
  localparam int B_W   = 5;
  localparam int LIM_W = 13;
  localparam int unsigned LIMIT = (1 << LIM_W) - 1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_multiplier_if #(.A_W(A_W), .B_W(B_W)) bus ();

  seq_multiplier #(.A_W(A_W), .B_W(B_W), .LIM_W(LIM_W)) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (actual running, required finished)");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: unsigned product and legal-domain overflow.
  function automatic int unsigned ref_prod(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    int unsigned ai;
    int unsigned bi;
    ai = a;
    bi = b;
    return ai * bi;
  endfunction

  // Issues one start and watches 12 cycles; operands are scrambled after capture.
  task automatic do_op(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                       output int lat, output int busy_n, output int done_n,
                       output logic [A_W+B_W-1:0] prod, output logic ovf);
    lat = 0; busy_n = 0; done_n = 0; prod = '0; ovf = 1'b0;
    bus.i_Start = 1'b1;
    bus.i_Multiplicand = a;
    bus.i_Multiplier = b;
    tick();
    bus.i_Start = 1'b0;
    if (bus.o_Busy === 1'b1) busy_n++;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      bus.i_Multiplicand = A_W'($urandom);
      bus.i_Multiplier   = B_W'($urandom);
      tick();
      if (bus.o_Busy === 1'b1) busy_n++;
      if (bus.o_Done === 1'b1) begin
        done_n++;
        if (lat == 0) begin
          lat  = cyc;
          prod = bus.o_Product;
          ovf  = bus.o_Ovf;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_Start = 1'b1;
    bus.i_Multiplicand = 10'd55;
    bus.i_Multiplier = 5'd9;
    tick();
    tick();
    rst = 1'b0;
    bus.i_Start = 1'b0;
    checks++; if (bus.o_Busy !== 1'b0) begin errors++; $display("FAIL reset_busy actual %b required 0", bus.o_Busy); end
    checks++; if (bus.o_Done !== 1'b0) begin errors++; $display("FAIL reset_done actual %b required 0", bus.o_Done); end
    checks++; if (bus.o_Product !== 15'd0) begin errors++; $display("FAIL reset_product actual %0d required 0", bus.o_Product); end
    checks++; if (bus.o_Ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf actual %b required 0", bus.o_Ovf); end
  endtask

  task automatic test_basic();
    int lat, busy_n, done_n;
    logic [A_W+B_W-1:0] prod;
    logic ovf;
    do_op(10'd100, 5'd5, lat, busy_n, done_n, prod, ovf);
    checks++; if (lat != 5) begin errors++; $display("FAIL basic_latency actual %0d required 5", lat); end
    checks++; if (busy_n != 6) begin errors++; $display("FAIL basic_busy_cycles actual %0d required 6", busy_n); end
    checks++; if (done_n != 1) begin errors++; $display("FAIL basic_done_pulses actual %0d required 1", done_n); end
    checks++; if (prod !== 15'd500) begin errors++; $display("FAIL basic_product actual %0d required 500", prod); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf actual %b required 0", ovf); end
    checks++; if (bus.o_Product !== 15'd500) begin errors++; $display("FAIL basic_product_held actual %0d required 500", bus.o_Product); end
  endtask

  task automatic test_ovf_boundary();
    logic [A_W-1:0] ta [4];
    logic [B_W-1:0] tb [4];
    int lat, busy_n, done_n;
    logic [A_W+B_W-1:0] prod;
    logic ovf;
    int unsigned e;
    ta = '{10'd1023, 10'd0, 10'd273, 10'd512};
    tb = '{5'd31, 5'd31, 5'd30, 5'd16};
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], lat, busy_n, done_n, prod, ovf);
      e = ref_prod(ta[i], tb[i]);
      checks++; if (prod !== 15'(e)) begin errors++; $display("FAIL ovf_product[%0d] actual %0d required %0d", i, prod, e); end
      checks++; if (ovf !== (e > LIMIT)) begin errors++; $display("FAIL ovf_flag[%0d] actual %b required %b", i, ovf, e > LIMIT); end
      checks++; if (lat != 5) begin errors++; $display("FAIL ovf_latency[%0d] actual %0d required 5", i, lat); end
      checks++; if (bus.o_Ovf !== (e > LIMIT)) begin errors++; $display("FAIL ovf_held[%0d] actual %b required %b", i, bus.o_Ovf, e > LIMIT); end
    end
  endtask

  task automatic test_random();
    int lat, busy_n, done_n;
    logic [A_W+B_W-1:0] prod;
    logic ovf;
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    int unsigned e;
    for (int i = 0; i < 20; i++) begin
      a = A_W'($urandom);
      b = B_W'($urandom);
      do_op(a, b, lat, busy_n, done_n, prod, ovf);
      e = ref_prod(a, b);
      checks++; if (prod !== 15'(e) || ovf !== (e > LIMIT) || lat != 5 || done_n != 1)
        begin errors++; $display("FAIL random[%0d] %0d*%0d actual prod %0d ovf %b lat %0d dones %0d required prod %0d ovf %b lat 5 dones 1",
                                 i, a, b, prod, ovf, lat, done_n, e, e > LIMIT); end
    end
  endtask

  task automatic test_start_ignored();
    int done_n, lat, busy_n;
    logic [A_W+B_W-1:0] prod;
    logic ovf;
    done_n = 0;
    prod = '0;
    bus.i_Start = 1'b1;
    bus.i_Multiplicand = 10'd10;
    bus.i_Multiplier = 5'd10;
    tick();
    bus.i_Start = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      bus.i_Start = 1'b0;
      if (bus.o_Done === 1'b1) begin
        done_n++;
        prod = bus.o_Product;
        // Start offered while in DONE must be ignored.
        bus.i_Start = 1'b1;
        bus.i_Multiplicand = 10'd7;
        bus.i_Multiplier = 5'd3;
      end
      if (cyc == 2) begin
        bus.i_Start = 1'b1;
        bus.i_Multiplicand = 10'd7;
        bus.i_Multiplier = 5'd3;
      end
    end
    bus.i_Start = 1'b0;
    checks++; if (done_n != 1) begin errors++; $display("FAIL ignore_done_pulses actual %0d required 1", done_n); end
    checks++; if (prod !== 15'd100) begin errors++; $display("FAIL ignore_product actual %0d required 100", prod); end
    checks++; if (bus.o_Busy !== 1'b0) begin errors++; $display("FAIL ignore_idle_after actual busy %b required 0", bus.o_Busy); end
    do_op(10'd7, 5'd3, lat, busy_n, done_n, prod, ovf);
    checks++; if (prod !== 15'd21 || lat != 5) begin errors++; $display("FAIL ignore_followup actual prod %0d lat %0d required prod 21 lat 5", prod, lat); end
  endtask

  task automatic test_reset_mid_run();
    int lat, busy_n, done_n;
    logic [A_W+B_W-1:0] prod;
    logic ovf;
    // Leave a nonzero result with overflow set so the reset clear is observable.
    do_op(10'd1023, 5'd31, lat, busy_n, done_n, prod, ovf);
    bus.i_Start = 1'b1;
    bus.i_Multiplicand = 10'd200;
    bus.i_Multiplier = 5'd17;
    tick();
    bus.i_Start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.o_Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy actual %b required 0", bus.o_Busy); end
    checks++; if (bus.o_Done !== 1'b0) begin errors++; $display("FAIL midrst_done actual %b required 0", bus.o_Done); end
    checks++; if (bus.o_Product !== 15'd0) begin errors++; $display("FAIL midrst_product actual %0d required 0", bus.o_Product); end
    checks++; if (bus.o_Ovf !== 1'b0) begin errors++; $display("FAIL midrst_ovf actual %b required 0", bus.o_Ovf); end
    done_n = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick();
      if (bus.o_Done === 1'b1 || bus.o_Busy === 1'b1) done_n++;
    end
    checks++; if (done_n != 0) begin errors++; $display("FAIL midrst_no_activity actual %0d active cycles required 0", done_n); end
    do_op(10'd12, 5'd12, lat, busy_n, done_n, prod, ovf);
    checks++; if (prod !== 15'd144 || lat != 5) begin errors++; $display("FAIL midrst_fresh actual prod %0d lat %0d required prod 144 lat 5", prod, lat); end
  endtask

  task automatic test_back_to_back();
    int done_n, last;
    done_n = 0;
    last = 0;
    bus.i_Start = 1'b1;
    bus.i_Multiplicand = 10'd3;
    bus.i_Multiplier = 5'd4;
    tick();
    for (int cyc = 1; cyc <= 35; cyc++) begin
      tick();
      if (bus.o_Done === 1'b1) begin
        done_n++;
        checks++; if (cyc - last != ((last == 0) ? 5 : 7)) begin errors++;
          $display("FAIL b2b_interval[%0d] actual %0d required %0d", done_n, cyc - last, (last == 0) ? 5 : 7); end
        checks++; if (bus.o_Product !== 15'd12) begin errors++;
          $display("FAIL b2b_product[%0d] actual %0d required 12", done_n, bus.o_Product); end
        last = cyc;
        bus.i_Multiplicand = 10'd3;
        bus.i_Multiplier = 5'd4;
      end else if (bus.o_Busy === 1'b1) begin
        bus.i_Multiplicand = A_W'($urandom);
        bus.i_Multiplier = B_W'($urandom);
      end
    end
    bus.i_Start = 1'b0;
    checks++; if (done_n != 5) begin errors++; $display("FAIL b2b_pulse_count actual %0d required 5", done_n); end
    for (int cyc = 0; cyc < 10; cyc++) tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.i_Start = 1'b0;
    bus.i_Multiplicand = '0;
    bus.i_Multiplier = '0;
    test_reset();
    test_basic();
    test_ovf_boundary();
    test_random();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
